rom_rd_pipe: RTL and testbench

- Parametrised, read-only word memory with an elastic request/response pipeline. Successor to the fixed 19x64 debug ROM.
- Generalised in data width, depth and read latency. Adds a req/gnt handshake, response backpressure and an out-of-range error response.
- Sits behind the debug module's slave bus adapter. Also reused for boot and trap stubs.

---
 rtl/rom_rd_pipe.sv | 118 +++++++++++
 tb/tb_rom_rd_pipe.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rom_rd_pipe.sv
// Read-only word memory behind a req/gnt handshake. The lookup happens when a
// request is accepted, then the word moves through an elastic pipeline that closes up bubbles.
`timescale 1ns/1ps
module rom_rd_pipe #(
  parameter int DataWidth   = 64,
  parameter int Depth       = 19,
  parameter int AddrWidth   = 64,
  parameter int ReadLatency = 1,
  parameter bit CheckUpper  = 1'b1,
  parameter logic [Depth-1:0][DataWidth-1:0] RomInit = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [AddrWidth-1:0] addr_i,
  output logic                 rvalid_o,
  input  logic                 rready_i,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 err_o
);

  localparam int OffW = $clog2(DataWidth / 8);
  localparam int IdxW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int UpLo = OffW + IdxW;
  localparam int L    = ReadLatency;
  localparam logic [IdxW:0] DepthC = (IdxW + 1)'(Depth);

  if (ReadLatency < 1 || ReadLatency > 4) begin : g_bad_latency
    $error("rom_rd_pipe: ReadLatency must be within 1..4");
  end
  if (DataWidth % 8 != 0 || DataWidth < 8) begin : g_bad_width
    $error("rom_rd_pipe: DataWidth must be a non-zero multiple of 8");
  end
  if (Depth < 1) begin : g_bad_depth
    $error("rom_rd_pipe: Depth must be at least 1");
  end

  logic [IdxW-1:0] idx;
  logic            upper_nz;
  logic            oor;
  logic            accept;
  logic            unused_addr;
  logic [DataWidth-1:0] rom_word;

  assign idx         = addr_i[OffW +: IdxW];
  assign unused_addr = ^addr_i;

  if (CheckUpper && (UpLo < AddrWidth)) begin : g_upper
    assign upper_nz = |addr_i[AddrWidth-1:UpLo];
  end else begin : g_no_upper
    assign upper_nz = 1'b0;
  end

  // Widen idx by one bit so Depth == 2**IdxW compares correctly.
  assign oor = ({1'b0, idx} >= DepthC) || upper_nz;

  always_comb begin
    rom_word = '0;
    for (int i = 0; i < Depth; i++) begin
      if (idx == IdxW'(i)) rom_word = RomInit[i];
    end
  end

  logic [L-1:0]                valid_q, valid_d;
  logic [L-1:0]                err_q, err_d;
  logic [L-1:0][DataWidth-1:0] data_q, data_d;
  logic [L-1:0]                free;

  // A stage is free when it, or any stage downstream of it, is empty, or the
  // consumer pops this cycle.
  always_comb begin
    for (int k = 0; k < L; k++) begin
      free[k] = rready_i;
      for (int j = k; j < L; j++) begin
        if (!valid_q[j]) free[k] = 1'b1;
      end
    end
  end

  assign gnt_o  = free[0];
  assign accept = req_i && free[0];

  always_comb begin
    valid_d = valid_q;
    err_d   = err_q;
    data_d  = data_q;
    for (int k = L - 1; k >= 1; k--) begin
      if (free[k]) begin
        valid_d[k] = valid_q[k-1];
        err_d[k]   = err_q[k-1];
        data_d[k]  = data_q[k-1];
      end
    end
    if (free[0]) begin
      valid_d[0] = accept;
      err_d[0]   = accept && oor;
      data_d[0]  = (accept && !oor) ? rom_word : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      err_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign rvalid_o = valid_q[L-1];
  assign err_o    = err_q[L-1];
  assign rdata_o  = data_q[L-1];

endmodule

// File: tb/tb_rom_rd_pipe.sv
// Bench for rom_rd_pipe: a 64-bit/latency-2 instance is checked against a response
// queue model, and three 32-bit instances (latency 1, 3, 4) are checked by directed single reads.
`timescale 1ns/1ps
module tb_rom_rd_pipe;

  function automatic logic [18:0][63:0] mk64();
    logic [18:0][63:0] r;
    for (int i = 0; i < 19; i++) r[i] = {32'hA5A50000 + 32'(i), 32'(i)};
    return r;
  endfunction
  function automatic logic [18:0][31:0] mk32();
    logic [18:0][31:0] r;
    for (int i = 0; i < 19; i++) r[i] = 32'hC0DE0000 + 32'(i);
    return r;
  endfunction
  localparam logic [18:0][63:0] ROM64 = mk64();
  localparam logic [18:0][31:0] ROM32 = mk32();

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        rready = 1'b1;
  logic [63:0] addr = '0;

  logic gnt_m, rv_m, er_m; logic [63:0] rd_m;
  logic gnt_1, rv_1, er_1; logic [31:0] rd_1;
  logic gnt_3, rv_3, er_3; logic [31:0] rd_3;
  logic gnt_4, rv_4, er_4; logic [31:0] rd_4;

  int n_assert = 0;
  int n_fail   = 0;
  int pops     = 0;
  logic [64:0] exp_q[$];

  always #5 clk = ~clk;

  rom_rd_pipe #(.DataWidth(64), .Depth(19), .AddrWidth(64), .ReadLatency(2), .CheckUpper(1'b1),
                .RomInit(ROM64)) u_main (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt_m), .addr_i(addr),
    .rvalid_o(rv_m), .rready_i(rready), .rdata_o(rd_m), .err_o(er_m));
  rom_rd_pipe #(.DataWidth(32), .Depth(19), .AddrWidth(64), .ReadLatency(1), .CheckUpper(1'b1),
                .RomInit(ROM32)) u_l1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt_1), .addr_i(addr),
    .rvalid_o(rv_1), .rready_i(rready), .rdata_o(rd_1), .err_o(er_1));
  rom_rd_pipe #(.DataWidth(32), .Depth(19), .AddrWidth(64), .ReadLatency(3), .CheckUpper(1'b1),
                .RomInit(ROM32)) u_l3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt_3), .addr_i(addr),
    .rvalid_o(rv_3), .rready_i(rready), .rdata_o(rd_3), .err_o(er_3));
  rom_rd_pipe #(.DataWidth(32), .Depth(19), .AddrWidth(64), .ReadLatency(4), .CheckUpper(1'b1),
                .RomInit(ROM32)) u_l4 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt_4), .addr_i(addr),
    .rvalid_o(rv_4), .rready_i(rready), .rdata_o(rd_4), .err_o(er_4));

  // Expected response {err, data} for a byte address, straight from the address map.
  function automatic logic [64:0] m64(input logic [63:0] a);
    int unsigned i = 32'(a[7:3]);
    logic bad = (i >= 19) || (a[63:8] != 0);
    return bad ? {1'b1, 64'd0} : {1'b0, 32'hA5A50000 + i, i};
  endfunction
  function automatic logic [64:0] m32(input logic [63:0] a);
    int unsigned i = 32'(a[6:2]);
    logic bad = (i >= 19) || (a[63:7] != 0);
    return bad ? {1'b1, 64'd0} : {1'b0, 32'd0, 32'hC0DE0000 + i};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic lat_chk(input string tag, input int k, input int lat, input logic rv,
                         input logic [63:0] rd, input logic er, input logic [64:0] e);
    chk({tag, "_rvalid"}, {63'd0, rv}, {63'd0, k == lat});
    if (k == lat) begin
      chk({tag, "_rdata"}, rd, e[63:0]);
      chk({tag, "_err"}, {63'd0, er}, {63'd0, e[64]});
    end
  endtask

  // One isolated request seen by all four instances; latency and word are checked per instance.
  task automatic single(input logic [63:0] a);
    @(posedge clk); #1; req = 1'b1; addr = a; rready = 1'b1;
    @(negedge clk);
    chk("single_gnt", {60'd0, gnt_m, gnt_1, gnt_3, gnt_4}, 64'hF);
    @(posedge clk); #1; req = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      lat_chk("lat2_w64", k, 2, rv_m, rd_m, er_m, m64(a));
      lat_chk("lat1_w32", k, 1, rv_1, {32'd0, rd_1}, er_1, m32(a));
      lat_chk("lat3_w32", k, 3, rv_3, {32'd0, rd_3}, er_3, m32(a));
      lat_chk("lat4_w32", k, 4, rv_4, {32'd0, rd_4}, er_4, m32(a));
    end
  endtask

  // One cycle on the latency-2 instance, scored against the response queue.
  // The pipeline holds exactly as many responses as the queue, so it is full
  // (and must refuse) only when the queue holds 2 and the consumer stalls.
  task automatic cyc(input logic r, input logic [63:0] a, input logic rr);
    logic [64:0] h;
    @(posedge clk); #1; req = r; addr = a; rready = rr;
    @(negedge clk);
    chk("gnt", {63'd0, gnt_m}, {63'd0, !(exp_q.size() == 2 && !rr)});
    chk("spurious_rvalid", {63'd0, rv_m && exp_q.size() == 0}, 64'd0);
    if (rv_m && exp_q.size() > 0) begin
      h = exp_q[0];
      chk("rdata", rd_m, h[63:0]);
      chk("err", {63'd0, er_m}, {63'd0, h[64]});
      if (rr) begin
        void'(exp_q.pop_front());
        pops++;
      end
    end
    if (r && gnt_m) exp_q.push_back(m64(a));
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    case ($urandom_range(0, 3))
      0: a = {56'd0, 5'($urandom_range(0, 18)), 3'($urandom_range(0, 7))};
      1: a = {56'd0, 5'($urandom_range(19, 31)), 3'($urandom_range(0, 7))};
      2: a = (64'd1 << $urandom_range(8, 63)) | 64'($urandom_range(0, 255));
      default: a = {$urandom, $urandom};
    endcase
    return a;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rvalid", {60'd0, rv_m, rv_1, rv_3, rv_4}, 64'd0);
    chk("reset_err", {60'd0, er_m, er_1, er_3, er_4}, 64'd0);
    chk("reset_rdata", rd_m | {32'd0, rd_1 | rd_3 | rd_4}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("gnt_after_reset", {60'd0, gnt_m, gnt_1, gnt_3, gnt_4}, 64'hF);

    // Isolated reads: in range, boundary, upper bits, byte offset.
    single(64'h18);
    single(64'h98);
    single(64'h90);
    single(64'h1_0000_0000);
    single(64'h1F);
    single(64'h4C);
    single(64'h48);
    single(64'h80);

    // Back-to-back words 0..18 at full rate.
    pops = 0;
    for (int i = 0; i < 19; i++) cyc(1'b1, 64'(i * 8), 1'b1);
    for (int i = 0; i < 2; i++) cyc(1'b0, 64'd0, 1'b1);
    chk("b2b_pops", 64'(pops), 64'd19);
    chk("b2b_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure: two accepted, the third refused while the head is held.
    cyc(1'b1, 64'h08, 1'b0);
    cyc(1'b1, 64'h10, 1'b0);
    cyc(1'b1, 64'h98, 1'b0);
    cyc(1'b1, 64'h98, 1'b0);
    cyc(1'b1, 64'h98, 1'b0);
    cyc(1'b1, 64'h98, 1'b1);
    cyc(1'b1, 64'h20, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 64'd0, 1'b1);
    chk("bp_empty", 64'(exp_q.size()), 64'd0);

    // Random traffic with random consumer stalls.
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), rand_addr(), 1'($urandom_range(0, 9) < 7));
    for (int i = 0; i < 6; i++) cyc(1'b0, 64'd0, 1'b1);
    chk("rand_empty", 64'(exp_q.size()), 64'd0);

    // Reset with two responses in flight.
    cyc(1'b1, 64'h28, 1'b0);
    cyc(1'b1, 64'h30, 1'b0);
    @(posedge clk); #1; req = 1'b0;
    #1;
    chk("inflight_rvalid", {63'd0, rv_m}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_rvalid", {63'd0, rv_m}, 64'd0);
    chk("async_rst_rdata", rd_m, 64'd0);
    chk("async_rst_err", {63'd0, er_m}, 64'd0);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) cyc(1'b0, 64'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
